// File: rtl/bias_pkg.sv
// Layer codes, bias BRAM address map and sequencer state encoding, shared by
// the bias BRAM and its read sequencer so the map lives in one place.
package bias_pkg;

    typedef enum logic [1:0] {
        LAYER_C1   = 2'd0,
        LAYER_C3   = 2'd1,
        LAYER_C5   = 2'd2,
        LAYER_NONE = 2'd3
    } layer_e;

    localparam int C1_START = 0;
    localparam int C1_CHANS = 2;
    localparam int C3_START = 2;
    localparam int C3_CHANS = 4;
    localparam int C5_START = 6;
    localparam int C5_CHANS = 43;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_e;

    function automatic int layer_start(input logic [1:0] layer);
        case (layer)
            LAYER_C1: return C1_START;
            LAYER_C3: return C3_START;
            default:  return C5_START;
        endcase
    endfunction

    function automatic int layer_chans(input logic [1:0] layer);
        case (layer)
            LAYER_C1: return C1_CHANS;
            LAYER_C3: return C3_CHANS;
            default:  return C5_CHANS;
        endcase
    endfunction

    function automatic int layer_end(input logic [1:0] layer);
        return layer_start(layer) + layer_chans(layer) - 1;
    endfunction

endpackage

// File: rtl/bias_skid_fifo.sv
// Two-entry FIFO holding {last, idx, bias} beats between the BRAM read port
// and the downstream valid/ready interface.
module bias_skid_fifo #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      count_reg;
    logic [1:0][W-1:0] entries;
    logic            push_ok;
    logic            pop_ok;

    assign full  = (count_reg == 2'd2);
    assign empty = (count_reg == 2'd0);
    assign count = count_reg;

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (srst) begin
                    data_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= din;
                end
            end
            assign entries[gi] = data_reg;
        end
    endgenerate

    assign dout = entries[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/bias_fetch.sv
// Bias read sequencer: walks one layer's bias BRAM range, absorbs the 1-cycle
// read latency and streams one signed bias per output channel over valid/ready.
module bias_fetch
    import bias_pkg::*;
#(
    parameter int AWIDTH = 6,
    parameter int B_BW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        layer,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] b_addr,
    output logic              b_ce,
    output logic              b_we,
    input  logic [B_BW-1:0]   b_q,
    output logic [B_BW-1:0]   bias_out,
    output logic [AWIDTH-1:0] bias_idx,
    output logic              bias_valid,
    input  logic              bias_ready,
    output logic              bias_last
);

    localparam int FW = 1 + AWIDTH + B_BW;

    fetch_state_e      state_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [AWIDTH-1:0] base_reg;
    logic [AWIDTH-1:0] end_reg;
    logic              inflight_reg;
    logic [AWIDTH-1:0] inflight_idx_reg;
    logic              inflight_last_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [FW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy_eff;

    assign pop = bias_valid && bias_ready;

    // Occupancy counts the head as gone when it is accepted this cycle; that
    // credit is what keeps a full-rate stream free of bubbles.
    assign occupancy_eff = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue = (state_reg == ST_FETCH) && !fifo_full && (occupancy_eff < 3'd2);

    assign b_ce   = issue;
    assign b_addr = addr_reg;
    assign b_we   = 1'b0;
    assign busy   = busy_reg;
    assign done   = done_reg;

    bias_skid_fifo #(
        .W(FW)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (inflight_reg),
        .din   ({inflight_last_reg, inflight_idx_reg, b_q}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bias_valid = !fifo_empty;
    assign bias_out   = fifo_dout[B_BW-1:0];
    assign bias_idx   = fifo_dout[B_BW+AWIDTH-1:B_BW];
    assign bias_last  = fifo_dout[FW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            addr_reg          <= '0;
            base_reg          <= '0;
            end_reg           <= '0;
            inflight_reg      <= 1'b0;
            inflight_idx_reg  <= '0;
            inflight_last_reg <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            // Tag travels alongside the read so the FIFO entry knows its channel.
            inflight_reg      <= issue;
            inflight_idx_reg  <= addr_reg - base_reg;
            inflight_last_reg <= (addr_reg == end_reg);
            done_reg          <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start && (layer != LAYER_NONE)) begin
                        addr_reg  <= AWIDTH'(layer_start(layer));
                        base_reg  <= AWIDTH'(layer_start(layer));
                        end_reg   <= AWIDTH'(layer_end(layer));
                        busy_reg  <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        if (addr_reg == end_reg) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && bias_last) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_fetch.sv
// Self-checking bench for bias_fetch: table of layer commands, BRAM model,
// scoreboard of expected beats, plus reset/negative-bias sequences.
module tb_bias_fetch;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] layer;
    logic       busy;
    logic       done;
    logic [5:0] b_addr;
    logic       b_ce;
    logic       b_we;
    logic [7:0] b_q;
    logic [7:0] bias_out;
    logic [5:0] bias_idx;
    logic       bias_valid;
    logic       bias_ready;
    logic       bias_last;

    bias_fetch #(.AWIDTH(6), .B_BW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .layer      (layer),
        .busy       (busy),
        .done       (done),
        .b_addr     (b_addr),
        .b_ce       (b_ce),
        .b_we       (b_we),
        .b_q        (b_q),
        .bias_out   (bias_out),
        .bias_idx   (bias_idx),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .bias_last  (bias_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem [0:63];
    always @(posedge clk) begin
        if (b_ce) b_q <= mem[b_addr];
    end

    typedef struct {
        logic [7:0] data;
        logic [5:0] idx;
        logic       last;
    } beat_t;

    typedef struct {
        logic [1:0] layer;
        bit         toggle;
        bit         poke;
        int         exp_beats;
        int         exp_valid_lat;
        int         exp_done_lat;
        int         exp_busy;
    } vec_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_addr = 0;
    int issued = 0;
    int accepted = 0;
    int beats_seen = 0;
    bit hold_v = 0;
    logic [7:0] hold_data;
    logic [5:0] hold_idx;
    logic       hold_last;

    function automatic int lay_start(input logic [1:0] l);
        case (l)
            2'd0: return 0;
            2'd1: return 2;
            default: return 6;
        endcase
    endfunction

    function automatic int lay_chans(input logic [1:0] l);
        case (l)
            2'd0: return 2;
            2'd1: return 4;
            default: return 43;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: address sequencing, read throttling, beat stability and scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 0;
        end else begin
            if (b_ce) begin
                checks++;
                if (b_addr !== 6'(exp_addr)) begin
                    errors++;
                    $display("FAIL read_addr: got %0d expected %0d", b_addr, exp_addr);
                end
                if (!bias_ready) begin
                    checks++;
                    if (issued - accepted >= 2) begin
                        errors++;
                        $display("FAIL read_throttle: issued with %0d outstanding, expected < 2", issued - accepted);
                    end
                end
                exp_addr++;
                issued++;
            end
            if (hold_v) begin
                checks++;
                if (bias_valid !== 1'b1 || bias_out !== hold_data || bias_idx !== hold_idx
                    || bias_last !== hold_last) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%0b d=%02h i=%0d l=%0b expected v=1 d=%02h i=%0d l=%0b",
                             bias_valid, bias_out, bias_idx, bias_last, hold_data, hold_idx, hold_last);
                end
            end
            if (bias_valid && bias_ready) begin
                hold_v = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got d=%02h i=%0d expected no beat", bias_out, bias_idx);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (bias_out !== e.data || bias_idx !== e.idx || bias_last !== e.last) begin
                        errors++;
                        $display("FAIL beat: got d=%02h i=%0d l=%0b expected d=%02h i=%0d l=%0b",
                                 bias_out, bias_idx, bias_last, e.data, e.idx, e.last);
                    end
                end
                $display("beat idx=%0d data=%02h last=%0b", bias_idx, bias_out, bias_last);
                accepted++;
                beats_seen++;
            end else if (bias_valid) begin
                hold_v    = 1;
                hold_data = bias_out;
                hold_idx  = bias_idx;
                hold_last = bias_last;
            end else begin
                hold_v = 0;
            end
        end
    end

    task automatic issue_start(input logic [1:0] l);
        int s;
        int n;
        beats_seen = 0;
        if (l != 2'd3) begin
            s = lay_start(l);
            n = lay_chans(l);
            exp_addr = s;
            issued = 0;
            accepted = 0;
            for (int a = s; a < s + n; a++) begin
                beat_t e;
                e.data = mem[a];
                e.idx  = 6'(a - s);
                e.last = (a == s + n - 1);
                exp_q.push_back(e);
            end
        end
        $display("cmd start layer=%0d", l);
        layer = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v);
        int first_v;
        int done_k;
        int busy_n;
        int done_n;
        bit valid_seen;
        bit ready_pat [3];
        ready_pat[0] = 1'b1;
        ready_pat[1] = 1'b0;
        ready_pat[2] = 1'b0;
        first_v = -1;
        done_k = -1;
        busy_n = 0;
        done_n = 0;
        valid_seen = 0;
        bias_ready = 1'b1;
        issue_start(v.layer);
        for (int k = 0; k < 150; k++) begin
            if (k == 0) chk("busy_after_start", int'(busy), (v.layer != 2'd3) ? 1 : 0);
            if (done_k >= 0 && k > done_k) begin
                chk("busy_after_done", int'(busy), 0);
                chk("done_one_cycle", int'(done), 0);
                break;
            end
            if (bias_valid) valid_seen = 1;
            if (bias_valid && first_v < 0) first_v = k;
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (busy && !done) busy_n++;
            if (v.layer == 2'd3 && k == 8) break;
            if (v.poke) begin
                start = (k == 10);
                if (k == 10) layer = 2'd1;
            end
            bias_ready = v.toggle ? ready_pat[k % 3] : 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        bias_ready = 1'b1;
        chk("beat_count", beats_seen, v.exp_beats);
        chk("scoreboard_left", exp_q.size(), 0);
        if (v.layer == 2'd3) begin
            chk("ignored_busy", busy_n, 0);
            chk("ignored_valid", int'(valid_seen), 0);
            chk("ignored_done", done_n, 0);
        end else begin
            chk("first_valid_lat", first_v, v.exp_valid_lat);
            chk("done_pulses", done_n, 1);
            if (v.exp_done_lat >= 0) chk("done_lat", done_k, v.exp_done_lat);
            if (v.exp_busy >= 0) chk("busy_cycles", busy_n, v.exp_busy);
        end
    endtask

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // layer, toggle-ready, poke start, beats, first-valid, done, busy-not-done cycles
        vecs[0] = '{2'd0, 1'b0, 1'b0, 2,  2, 4,  4};
        vecs[1] = '{2'd1, 1'b1, 1'b0, 4,  2, -1, -1};
        vecs[2] = '{2'd2, 1'b0, 1'b1, 43, 2, 45, 45};
        vecs[3] = '{2'd3, 1'b0, 1'b0, 0, -1, -1, -1};
        vecs[4] = '{2'd1, 1'b0, 1'b0, 4,  2, 6,  6};

        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
        rst = 1'b1;
        start = 1'b0;
        layer = 2'd0;
        bias_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_b_ce", int'(b_ce), 0);
        chk("rst_b_addr", int'(b_addr), 0);
        chk("rst_b_we", int'(b_we), 0);
        chk("rst_valid", int'(bias_valid), 0);
        chk("rst_out", int'(bias_out), 0);
        chk("rst_idx", int'(bias_idx), 0);
        chk("rst_last", int'(bias_last), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

        // Negative biases in the C3 range must pass through untouched.
        mem[3] = 8'h80;
        mem[4] = 8'hFF;
        run_cmd(vecs[4]);
        mem[3] = 8'h13;
        mem[4] = 8'h14;

        // Reset in the middle of a C5 stream.
        bias_ready = 1'b1;
        issue_start(2'd2);
        for (int k = 0; k < 100 && beats_seen < 20; k++) begin
            @(posedge clk); #1;
        end
        chk("beats_before_rst", beats_seen, 20);
        bias_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_b_ce", int'(b_ce), 0);
        chk("midrst_b_addr", int'(b_addr), 0);
        chk("midrst_valid", int'(bias_valid), 0);
        chk("midrst_out", int'(bias_out), 0);
        chk("midrst_idx", int'(bias_idx), 0);
        chk("midrst_last", int'(bias_last), 0);
        rst = 1'b0;
        exp_q.delete();
        begin
            int dn;
            int vn;
            dn = 0;
            vn = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (done) dn++;
                if (bias_valid || busy) vn++;
            end
            chk("midrst_no_done", dn, 0);
            chk("midrst_idle", vn, 0);
        end
        run_cmd(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_fetch.md
# bias_fetch

Bias read sequencer downstream of the dual-port bias BRAM in the LeNet accelerator. On a per-layer command it walks the BRAM address range of the selected layer (C1, C3 or C5), absorbs the BRAM's 1-cycle read latency, and streams one signed 8-bit bias per output channel to the bias-add stage over a valid/ready handshake. It owns one BRAM port in read-only mode.

## Interface
- AWIDTH, 6, BRAM address width
- B_BW, 8, bias word width (signed two's complement)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle command strobe, sampled only in IDLE
- layer  in  2  layer select: 0=C1, 1=C3, 2=C5, 3=invalid
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse after the last beat handshake
- b_addr  out  AWIDTH  BRAM read address
- b_ce  out  1  BRAM chip enable
- b_we  out  1  BRAM write enable, constant 0
- b_q  in  B_BW  BRAM read data, valid one cycle after b_ce
- bias_out  out  B_BW  bias value
- bias_idx  out  AWIDTH  channel index within layer, starting at 0
- bias_valid  out  1  output beat valid
- bias_ready  in  1  downstream accept
- bias_last  out  1  marks final channel of the layer

## Operation
- Address map: C1 0..1 (2 ch), C3 2..5 (4 ch), C5 6..48 (43 ch).
- FSM: IDLE -> FETCH on start with layer≠3; FETCH -> DRAIN when the last address is issued; DRAIN -> DONE when the last beat handshakes; DONE -> IDLE unconditionally (1 cycle, done=1).
- start with layer=3, or any start outside IDLE: ignored, no state change, no output.
- Read issue: b_ce=1 with b_addr=next address only when (FIFO occupancy + reads in flight) < 2. Address increments per issued read, never past layer end.
- Returned b_q enters a 2-entry output FIFO tagged with idx and last; FIFO head drives bias_out/bias_idx/bias_last.
- Handshake: beat transfers when bias_valid & bias_ready. While bias_ready=0, bias_out/idx/last stay stable and bias_valid stays high.
- bias_idx = address − layer start; bias_last=1 iff address = layer end.

## Timing
- Reset values: busy=0, done=0, b_ce=0, b_addr=0, b_we=0, bias_valid=0, bias_out=0, bias_idx=0, bias_last=0; FSM IDLE; FIFO empty.
- start sampled at edge T: busy and first b_ce/b_addr=start visible after T; first bias_valid visible after edge T+2.
- With bias_ready held 1: one beat per cycle, no bubbles; C1 completes with done visible after edge T+4.
- done asserted the cycle after the last handshake; busy drops with it going to IDLE; new start accepted the cycle after done.
- FIFO full and bias_ready=0: b_ce=0 that cycle; no read lost or duplicated.
- rst mid-operation: all state and FIFO flushed next edge, outputs to reset values, in-flight read data discarded, no done pulse.

## Structure
- Shared package bias_pkg: layer codes (LAYER_C1/C3/C5), per-layer start/end addresses, channel counts; also imported by the bias BRAM so the address map is single-source.
- One sub-module: bias_skid_fifo, 2-entry FIFO of {last, idx, bias} with push/pop, full/empty, synchronous reset.
- Top: FSM, address counter, in-flight flag, FIFO instance.

## Test plan
- BRAM preloaded addr n = n+0x10; layer=0, ready=1 -> beats 0x10 (idx0), 0x11 (idx1, last), valid from T+2, done one cycle after beat 2.
- layer=1, ready toggling 1,0,0,1,... -> exactly 4 beats 0x12..0x15, idx 0..3, data stable while ready=0, b_ce never issued with FIFO full.
- layer=2, ready=1 -> 43 consecutive beats 0x16..0x40, last only on idx 42, done once, busy high 45 cycles.
- start pulsed during C5 run and start with layer=3 in IDLE -> both ignored, no extra beats, busy unchanged.
- Negative biases (0x80, 0xFF) at C3 addresses -> passed bit-exact.
- rst asserted at beat 20 of C5 -> next cycle all outputs 0, FSM IDLE, no done; subsequent C1 run produces correct 2 beats.
